// File: rtl/mux_nto1_rr.sv
// Purpose: N-to-1 registered multiplexer with per-channel valid/ready and manual or round-robin selection.
// Latency: 1 cycle from input transfer (in_valid & in_ready) to out_valid.
// Backpressure: out_ready=0 with out_valid=1 holds the output register and drops every in_ready.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset (sync release expected upstream)
//   in_data / in_valid    packed channel data (channel k at [k*WIDTH +: WIDTH]) and per-channel valid
//   in_ready              per-channel accept strobe, combinational, at most one bit set
//   mode, sel             0 = manual (sel chooses the channel), 1 = round-robin scan
//   out_data/out_ch       registered word and the index of the channel it came from
//   out_valid/out_ready   output handshake
// Optional build macro MUX_NTO1_PARITY_EN adds:
//   in_parity             per-channel even-parity bit for in_data
//   out_parity            registered even parity over out_data
//   parity_err            one-cycle pulse alongside the word whose in_parity did not match

module mux_nto1_rr #(
    parameter int  NUM_CH = 4,
    parameter int  WIDTH  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*WIDTH-1:0]  in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
`ifdef MUX_NTO1_PARITY_EN
    input  logic [NUM_CH-1:0]        in_parity,
    output logic                     out_parity,
    output logic                     parity_err,
`endif
    input  logic                     out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;
`ifdef MUX_NTO1_PARITY_EN
    logic              r_out_parity;
    logic              r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  w_ch_data [NUM_CH];
    logic [SEL_W-1:0]  w_rr_idx  [NUM_CH];
    logic              w_load_en;
    logic              w_sel_ok;
    logic              w_man_vld;
    logic              w_rr_vld;
    logic [SEL_W-1:0]  w_rr_gnt;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt;
    logic [WIDTH-1:0]  w_gnt_data;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_rr_next;

    // Unpack the flat data bus into one word per channel.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Scan order for round-robin: w_rr_idx[i] = (rr_ptr + i) mod NUM_CH.
    // One extra bit in the sum keeps the wrap correct for non-power-of-2 NUM_CH.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_scan
        logic [SEL_W:0] w_sum;
        assign w_sum       = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
        assign w_rr_idx[i] = (w_sum >= (SEL_W+1)'(NUM_CH))
                           ? SEL_W'(w_sum - (SEL_W+1)'(NUM_CH))
                           : w_sum[SEL_W-1:0];
    end

    // The output register may take a new word when empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Manual mode: a select beyond the last channel simply grants nothing.
    assign w_sel_ok  = (int'(sel) < NUM_CH);
    assign w_man_vld = w_sel_ok && in_valid[sel];

    // Round-robin: first valid channel starting at rr_ptr.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_rr_vld && in_valid[w_rr_idx[i]]) begin
                w_rr_vld = 1'b1;
                w_rr_gnt = w_rr_idx[i];
            end
        end
    end

    assign w_gnt_vld  = mode ? w_rr_vld : w_man_vld;
    assign w_gnt      = mode ? w_rr_gnt : sel;
    assign w_gnt_data = w_ch_data[w_gnt];

    // A grant only turns into a transfer when the register can load; during
    // reset nothing is accepted so no upstream word is lost.
    assign w_xfer = rst_n && w_gnt_vld && w_load_en;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    // Pointer moves just past the channel served, wrapping at NUM_CH-1.
    assign w_rr_next = (w_gnt == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt + SEL_W'(1);

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_load_en) begin
                // Empty or draining: either refill or go empty; data/ch keep
                // their last values when nothing is granted.
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_gnt_data;
                    r_out_ch   <= w_gnt;
                end
            end
            if (w_xfer && mode) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

`ifdef MUX_NTO1_PARITY_EN
    // Parity travels with the word; the error flag is a single-cycle pulse
    // lined up with the first cycle the faulty word is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_parity <= ^w_gnt_data;
            end
            r_parity_err <= w_xfer && ((^w_gnt_data) != in_parity[w_gnt]);
        end
    end

    assign out_parity = r_out_parity;
    assign parity_err = r_parity_err;
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Purpose: self-checking bench for mux_nto1_rr (NUM_CH=4, WIDTH=8).
// Latency: expects each granted word on out_data one cycle after its transfer.
// Backpressure: exercises out_ready stalls, idle drain, skip/wrap and async reset.

module tb_mux_nto1_rr;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int SEL_W  = 2;

    localparam logic [31:0] D_RR = 32'h43_32_21_10;
    localparam logic [31:0] D_M  = 32'h43_C3_21_10;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;
`ifdef MUX_NTO1_PARITY_EN
    logic [NUM_CH-1:0]       in_parity;
    logic                    out_parity;
    logic                    parity_err;
    logic                    corrupt0 = 1'b0;

    always_comb begin
        in_parity = {^in_data[31:24], ^in_data[23:16], ^in_data[15:8],
                     (^in_data[7:0]) ^ corrupt0};
    end
`endif

    always #5 clk = ~clk;

    mux_nto1_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
`ifdef MUX_NTO1_PARITY_EN
        .in_parity (in_parity),
        .out_parity(out_parity),
        .parity_err(parity_err),
`endif
        .out_ready (out_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic             mode;
        logic [1:0]       sel;
        logic [3:0]       vld;
        logic             ordy;
        logic [31:0]      data;
        logic [3:0]       exp_rdy;
        logic             exp_ovld;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t last;

    task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                       input logic [31:0] d, input logic [3:0] er, input logic eo);
        vec_t x;
        x.mode = m; x.sel = s; x.vld = v; x.ordy = r; x.data = d;
        x.exp_rdy = er; x.exp_ovld = eo;
        vt.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Manual: sel=2 all valid
        add(0, 2, 4'hF, 1, D_M,  4'b0100, 1);
        add(0, 0, 4'hF, 1, D_M,  4'b0001, 1);
        // Round-robin, all valid: 0,1,2,3,0 (ptr starts at 0, manual left it alone)
        add(1, 0, 4'hF, 1, D_RR, 4'b0001, 1);
        add(1, 0, 4'hF, 1, D_RR, 4'b0010, 1);
        add(1, 0, 4'hF, 1, D_RR, 4'b0100, 1);
        add(1, 0, 4'hF, 1, D_RR, 4'b1000, 1);
        add(1, 0, 4'hF, 1, D_RR, 4'b0001, 1);
        // Skip/wrap with ch1,ch3 only: grant 1 puts ptr at 2, then 3,1,3,1
        add(1, 0, 4'hA, 1, D_RR, 4'b0010, 1);
        add(1, 0, 4'hA, 1, D_RR, 4'b1000, 1);
        add(1, 0, 4'hA, 1, D_RR, 4'b0010, 1);
        add(1, 0, 4'hA, 1, D_RR, 4'b1000, 1);
        add(1, 0, 4'hA, 1, D_RR, 4'b0010, 1);
        // Backpressure for 5 cycles, then drain+reload with no bubble (ptr=2)
        for (int i = 0; i < 5; i++) add(1, 0, 4'hF, 0, D_RR, 4'b0000, 1);
        add(1, 0, 4'hF, 1, D_RR, 4'b0100, 1);
        // Idle: out_valid falls, ptr stays 3
        add(1, 0, 4'h0, 1, D_RR, 4'b0000, 0);
        add(1, 0, 4'h0, 1, D_RR, 4'b0000, 0);
        add(1, 0, 4'hF, 1, D_RR, 4'b1000, 1);
        // Manual, selected channel not valid -> empty
        add(0, 1, 4'hD, 1, D_RR, 4'b0000, 0);
        // Empty register loads even with out_ready=0
        add(0, 1, 4'h2, 0, D_RR, 4'b0010, 1);
        add(0, 3, 4'hF, 0, D_RR, 4'b0000, 1);
        // Back to round-robin: ptr still 0 from before the manual segment
        add(1, 0, 4'hF, 1, D_RR, 4'b0001, 1);
        add(0, 3, 4'hF, 1, D_RR, 4'b1000, 1);

        // Reset phase
        rst_n = 1'b0; in_valid = 4'hF; in_data = D_RR; mode = 1'b0; sel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data",  out_data,  0);
        check("reset out_ch",    out_ch,    0);
        check("reset in_ready",  in_ready,  0);
        rst_n = 1'b1;
        last = '{d: 8'h00, ch: 2'd0};

        for (int i = 0; i < vt.size(); i++) begin
            mode = vt[i].mode; sel = vt[i].sel; in_valid = vt[i].vld;
            out_ready = vt[i].ordy; in_data = vt[i].data;
            #1;
            check($sformatf("v%0d in_ready", i), in_ready, vt[i].exp_rdy);
            for (int k = 0; k < NUM_CH; k++)
                if (vt[i].exp_rdy[k]) sb.push_back('{d: vt[i].data[k*8 +: 8], ch: 2'(k)});
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), out_valid, vt[i].exp_ovld);
            if (vt[i].exp_rdy != 4'b0000) last = sb.pop_front();
            check($sformatf("v%0d out_data", i), out_data, last.d);
            check($sformatf("v%0d out_ch", i),   out_ch,   last.ch);
        end

        // Async reset while a word is held: register clears at once
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = D_M; out_ready = 1'b1;
        #1;
        check("pre-reset in_ready", in_ready, 4'b0100);
        @(posedge clk);
        #1;
        check("pre-reset out_data", out_data, 8'hC3);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", out_valid, 0);
        check("mid-reset out_data",  out_data,  0);
        check("mid-reset out_ch",    out_ch,    0);
        check("mid-reset in_ready",  in_ready,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mode = 1'b1; in_data = D_RR; out_ready = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 4'b0001);
        @(posedge clk);
        #1;
        check("post-reset out_valid", out_valid, 1);
        check("post-reset out_data",  out_data,  8'h10);
        check("post-reset out_ch",    out_ch,    0);

`ifdef MUX_NTO1_PARITY_EN
        // Bad parity on ch0 -> one-cycle err pulse, word still forwarded
        mode = 1'b0; sel = 2'd0; in_valid = 4'hF; corrupt0 = 1'b1;
        @(posedge clk);
        #1;
        check("par bad err",      parity_err, 1);
        check("par bad data",     out_data,   8'h10);
        check("par bad out_par",  out_parity, 1);
        corrupt0 = 1'b0; sel = 2'd1;
        @(posedge clk);
        #1;
        check("par good err",     parity_err, 0);
        check("par good out_par", out_parity, 0);
        check("par good data",    out_data,   8'h21);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
